regfile_sb: RTL
===============

# regfile_sb

Parametrised multi-read-port integer register file with a per-register busy/tag scoreboard for the RISC-V core. It replaces the fixed two-read-port register file between decode/issue and writeback. Each architectural register holds data, a busy bit and the tag of its pending producer. Decode reads operands and readiness in the same cycle. Issue marks destinations busy. Writeback retires results by tag.

## Interface
Parameters:
- DATA_W, 32, register width
- ADDR_W, 5, register address width; NUM_REGS = 2**ADDR_W
- NUM_RD, 2, number of read ports (1..4)
- TAG_W, 4, producer tag width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- re  in  NUM_RD  read enable, one per port
- raddr  in  NUM_RD*ADDR_W  read addresses; port i uses bits [i*ADDR_W +: ADDR_W]
- rdata  out  NUM_RD*DATA_W  read data, combinational
- rbusy  out  NUM_RD  operand not yet ready, combinational
- rtag  out  NUM_RD*TAG_W  pending producer tag, combinational
- iss_valid  in  1  issue request: mark a destination busy
- iss_addr  in  ADDR_W  destination register for the issue request
- iss_tag  in  TAG_W  tag of the producing instruction
- we  in  1  writeback valid
- waddr  in  ADDR_W  writeback destination register
- wdata  in  DATA_W  writeback data
- wtag  in  TAG_W  tag of the instruction writing back
- flush  in  1  clear all busy bits (pipeline squash)
- busy_cnt  out  ADDR_W+1  registered count of busy registers

## Operation
- State per register r: data[r], busy[r], tag[r]. Register x0 reads 0, is never written and is never busy; iss_valid or we addressed to x0 is ignored.
- Writeback, when we && waddr != 0:
  - data[waddr] <= wdata, regardless of tag.
  - busy[waddr] <= 0 only if busy[waddr] && tag[waddr] == wtag. A stale tag updates data but leaves busy unchanged.
- Issue, when iss_valid && iss_addr != 0: busy[iss_addr] <= 1 and tag[iss_addr] <= iss_tag.
- Issue and writeback to the same register in the same cycle: issue wins for busy and tag. Data still takes wdata.
- Flush: all busy[r] <= 0; tags are kept. Writeback data in the same cycle is still written. An issue in the same cycle is dropped, so flush has priority over issue.
- Read port i, when re[i]=0 or raddr_i=0: rdata=0, rbusy=0, rtag=0.
- Read port i, otherwise: rdata=data[raddr_i], rbusy=busy[raddr_i], rtag=tag[raddr_i]; modified by forwarding (see Configuration).
- Reads never see a same-cycle issue; they see pre-issue state.
- busy_cnt equals the number of set busy bits after each edge. It is updated as a registered counter, not by recomputing a popcount over the whole array. Per-cycle delta is one of -1, 0 or +1:
  - +1 when an issue sets a previously clear bit.
  - -1 when a matching writeback clears a bit.
  - 0 when both happen on the same register, or neither changes state.
- flush sets busy_cnt <= 0.

## Timing
- Reset: on a clk edge with rst=1, all data, busy and tag entries go to 0 and busy_cnt goes to 0. While rst=1, rdata, rbusy and rtag are held at 0.
- rst has priority over flush, issue and writeback.
- Read latency 0 (combinational). Writeback and issue become visible at the next edge, or same-cycle via forwarding if enabled.
- No handshake and no stall: every input is accepted in the cycle it is presented.
- rst asserted mid-operation discards all pending busy state. No writeback after reset clears anything.

## Configuration
- REGFILE_BYPASS_EN defined: writeback-to-read forwarding. A read port with re[i], raddr_i != 0, we and waddr == raddr_i returns rdata = wdata. It also returns rbusy = 0 if busy[raddr_i] && tag[raddr_i] == wtag, otherwise the stored busy. rtag is the stored tag.
- REGFILE_BYPASS_EN undefined: reads return stored state only; a writeback is visible from the next cycle.
- All other behaviour is identical in both builds.

## Test plan
- Reset: write x5=0x1234, then rst=1 for one edge. Reads of x5 return 0, rbusy=0, busy_cnt=0.
- Issue/retire: issue x3 tag 7. Next cycle: rbusy=1, rtag=7, busy_cnt=1. Writeback x3=0xCAFE tag 7. Next cycle: rdata=0xCAFE, rbusy=0, busy_cnt=0.
- Stale tag: issue x4 tag 2, then issue x4 tag 9, then writeback x4 tag 2 with 0x55. Data=0x55, rbusy=1, rtag=9, busy_cnt=1.
- Same-cycle issue and writeback on x6: x6 busy with tag 1; issue x6 tag 3 while writeback x6 tag 1 with 0xAA. Result: busy=1, tag=3, data=0xAA, busy_cnt unchanged at 1.
- x0 and flush: issue and writeback to x0 give reads of 0, not busy. Issue x1, x2, x7 (busy_cnt=3), then flush with a simultaneous issue of x8. All rbusy=0, busy_cnt=0.
- Bypass with NUM_RD=3: writeback x9=0xBEEF with a matching tag while ports 0 and 2 read x9. With REGFILE_BYPASS_EN: same-cycle rdata=0xBEEF, rbusy=0. Without it: old data that cycle, 0xBEEF the next cycle.

Source files
------------

// File: rtl/regfile_sb.sv
// regfile_sb: multi-read-port integer register file with per-register busy/tag
// scoreboard. Decode reads operands and readiness combinationally, issue marks
// destinations busy, and writeback retires results by tag.
// Optional build macro: REGFILE_BYPASS_EN enables writeback-to-read forwarding.
module regfile_sb #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned TAG_W  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD-1:0]        re,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rbusy,
  output logic [NUM_RD*TAG_W-1:0]  rtag,
  input  logic                     iss_valid,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic [TAG_W-1:0]         iss_tag,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [TAG_W-1:0]         wtag,
  input  logic                     flush,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int unsigned NUM_REGS = 2 ** ADDR_W;
  localparam int unsigned CNT_W    = ADDR_W + 1;

  logic [DATA_W-1:0]   data_q [NUM_REGS];
  logic [TAG_W-1:0]    tag_q  [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic [CNT_W-1:0]    cnt_q;

  logic iss_ok;
  logic wb_ok;
  logic wb_match;
  logic cnt_inc;
  logic cnt_dec;
  logic [ADDR_W-1:0] rd_addr [NUM_RD];

  // Qualified update strobes; x0 is never a target and flush drops issue.
  always_comb begin
    iss_ok   = iss_valid && (iss_addr != '0) && !flush;
    wb_ok    = we && (waddr != '0);
    wb_match = wb_ok && busy_q[waddr] && (tag_q[waddr] == wtag);
    // A set of an already-busy bit adds nothing; a retire overridden by a
    // same-register issue removes nothing.
    cnt_inc  = iss_ok && !busy_q[iss_addr];
    cnt_dec  = wb_match && !(iss_ok && (iss_addr == waddr));
  end

  // Register array: data always takes writeback, issue overrides retire.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        data_q[r] <= '0;
        tag_q[r]  <= '0;
      end
      busy_q <= '0;
    end else begin
      if (wb_ok) data_q[waddr] <= wdata;
      if (flush) begin
        busy_q <= '0;
      end else begin
        if (wb_match) busy_q[waddr] <= 1'b0;
        if (iss_ok) begin
          busy_q[iss_addr] <= 1'b1;
          tag_q[iss_addr]  <= iss_tag;
        end
      end
    end
  end

  // Incremental busy counter, tracks popcount of busy_q one step at a time.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      cnt_q <= '0;
    end else if (cnt_inc && !cnt_dec) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end else if (cnt_dec && !cnt_inc) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign busy_cnt = cnt_q;

  // Combinational read ports; zero when disabled, addressing x0, or in reset.
  always_comb begin
    rdata = '0;
    rbusy = '0;
    rtag  = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      rd_addr[i] = raddr[i*ADDR_W +: ADDR_W];
      if (!rst && re[i] && (rd_addr[i] != '0)) begin
        rdata[i*DATA_W +: DATA_W] = data_q[rd_addr[i]];
        rbusy[i]                  = busy_q[rd_addr[i]];
        rtag[i*TAG_W +: TAG_W]    = tag_q[rd_addr[i]];
`ifdef REGFILE_BYPASS_EN
        // Forward same-cycle writeback; a matching tag also clears readiness.
        if (we && (waddr == rd_addr[i])) begin
          rdata[i*DATA_W +: DATA_W] = wdata;
          if (busy_q[rd_addr[i]] && (tag_q[rd_addr[i]] == wtag)) rbusy[i] = 1'b0;
        end
`endif
      end
    end
  end

endmodule
